// File: rtl/tbs_pkg.sv
// tbs_pkg: shared FSM state type, defaults and event width helper for the threshold-based ADC controller.
// Timestamps in the event word are enabled by defining TBS_TIMESTAMP_EN.
package tbs_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, SETTLE, COMPARE} state_t;
    localparam int DEF_DAC_WIDTH     = 10;
    localparam int DEF_DELTA_WIDTH   = 6;
    localparam int DEF_FIFO_DEPTH    = 8;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_TS_WIDTH      = 16;
`ifdef TBS_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif
    function automatic int evt_w(input int dac_w, input int ts_w);
        return 1 + dac_w + (TS_EN ? ts_w : 0);
    endfunction
endpackage

// File: rtl/tbs_evt_fifo.sv
// tbs_evt_fifo: first-word-fall-through event FIFO; a full FIFO still accepts a push when popped in the same cycle.
module tbs_evt_fifo
    import tbs_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_pop, do_push;
    assign empty_o = wr_ptr == rd_ptr;
    assign full_o  = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
        end
    end
    always_ff @(posedge clock_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/tbs_adc_ctrl.sv
// tbs_adc_ctrl: tracking threshold-based ADC controller driving a DAC window and logging crossing events.
// Define TBS_TIMESTAMP_EN to append a free-running timestamp to every event word.
module tbs_adc_ctrl
    import tbs_pkg::*;
#(
    parameter int DAC_WIDTH     = DEF_DAC_WIDTH,
    parameter int DELTA_WIDTH   = DEF_DELTA_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int TS_WIDTH      = DEF_TS_WIDTH,
    localparam int EVT_W        = evt_w(DAC_WIDTH, TS_WIDTH)
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   enable_i,
    input  logic                   comp_upper_i,
    input  logic                   comp_lower_i,
    input  logic [DELTA_WIDTH-1:0] delta_i,
    input  logic                   adaptive_i,
    output logic [DAC_WIDTH-1:0]   dac_upper_o,
    output logic [DAC_WIDTH-1:0]   dac_lower_o,
    output logic                   dac_wr_o,
    output logic                   evt_valid_o,
    input  logic                   evt_ready_i,
    output logic [EVT_W-1:0]       evt_data_o,
    output logic                   fifo_ovf_o,
    output logic                   sat_hi_o,
    output logic                   sat_lo_o,
    output logic                   busy_o
);
    localparam int AW = DAC_WIDTH + DELTA_WIDTH + 4;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DAC_WIDTH-1:0] MID = {1'b1, {(DAC_WIDTH-1){1'b0}}};
    localparam logic [DAC_WIDTH-1:0] MAX = '1;
    localparam logic [AW-1:0] MAX_W = AW'(MAX);
    state_t state;
    logic [1:0] up_sync, lo_sync, shift, eff_shift;
    logic [DAC_WIDTH-1:0] center, center_nxt, up_code, lo_code;
    logic [CW-1:0] cnt;
    logic [AW-1:0] c_w, d_w, step;
    logic up_s, lo_s, dir, prev_dir, has_prev, push, full, empty, drop;
    logic [EVT_W-1:0] evt_in;
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            up_sync <= '0;
            lo_sync <= '0;
        end else begin
            up_sync <= {up_sync[0], comp_upper_i};
            lo_sync <= {lo_sync[0], comp_lower_i};
        end
    end
    assign up_s = up_sync[1];
    assign lo_s = lo_sync[1];
    assign dir  = up_s;
    // Consecutive same-direction crossings widen the step; the first or a reversed one restarts it.
    assign eff_shift  = (adaptive_i && has_prev && dir == prev_dir) ? (shift == 2'd3 ? shift : shift + 2'd1) : 2'd0;
    assign c_w        = AW'(center);
    assign d_w        = AW'(delta_i);
    assign step       = d_w << eff_shift;
    assign up_code    = (c_w + d_w > MAX_W) ? MAX : DAC_WIDTH'(c_w + d_w);
    assign lo_code    = (d_w > c_w) ? '0 : DAC_WIDTH'(c_w - d_w);
    assign center_nxt = dir ? ((c_w + step > MAX_W) ? MAX : DAC_WIDTH'(c_w + step))
                            : ((step > c_w) ? '0 : DAC_WIDTH'(c_w - step));
    assign push       = enable_i && state == COMPARE && (up_s ^ lo_s);
    assign drop       = push && full && !evt_ready_i;
    assign sat_hi_o   = center == MAX;
    assign sat_lo_o   = center == '0;
    assign busy_o     = state != IDLE;
    assign evt_valid_o = !empty;
`ifdef TBS_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts;
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) ts <= '0;
        else ts <= ts + 1'b1;
    end
    assign evt_in = {dir, center_nxt, ts};
`else
    assign evt_in = {dir, center_nxt};
`endif
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= IDLE;
            center      <= MID;
            dac_upper_o <= MID;
            dac_lower_o <= MID;
            dac_wr_o    <= 1'b0;
            shift       <= '0;
            prev_dir    <= 1'b0;
            has_prev    <= 1'b0;
            cnt         <= '0;
            fifo_ovf_o  <= 1'b0;
        end else if (!enable_i) begin
            state      <= IDLE;
            dac_wr_o   <= 1'b0;
            fifo_ovf_o <= 1'b0;
        end else begin
            dac_wr_o   <= 1'b0;
            fifo_ovf_o <= fifo_ovf_o | drop;
            case (state)
                IDLE: begin
                    center   <= MID;
                    shift    <= '0;
                    has_prev <= 1'b0;
                    state    <= WRITE;
                end
                WRITE: begin
                    dac_upper_o <= up_code;
                    dac_lower_o <= lo_code;
                    dac_wr_o    <= 1'b1;
                    cnt         <= '0;
                    state       <= SETTLE;
                end
                SETTLE: begin
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CW'(SETTLE_CYCLES - 1)) ? COMPARE : SETTLE;
                end
                COMPARE: begin
                    if (up_s ^ lo_s) begin
                        center   <= center_nxt;
                        shift    <= eff_shift;
                        prev_dir <= dir;
                        has_prev <= 1'b1;
                        state    <= WRITE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    tbs_evt_fifo #(.WIDTH(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock_i  (clock_i),
        .reset_n_i(reset_n_i),
        .push_i   (push),
        .pop_i    (evt_ready_i),
        .data_i   (evt_in),
        .full_o   (full),
        .empty_o  (empty),
        .data_o   (evt_data_o)
    );
endmodule

// File: tb/tb_tbs_adc_ctrl.sv
// tb_tbs_adc_ctrl: directed self-checking bench for tbs_adc_ctrl in its default (no timestamp) build.
module tb_tbs_adc_ctrl;
    logic clock_i = 1'b0, reset_n_i = 1'b1, enable_i = 1'b0, adaptive_i = 1'b0, evt_ready_i = 1'b0;
    logic comp_upper_i = 1'b0, comp_lower_i = 1'b0;
    logic [5:0] delta_i = 6'd16;
    logic [9:0] dac_upper_o, dac_lower_o;
    logic dac_wr_o, evt_valid_o, fifo_ovf_o, sat_hi_o, sat_lo_o, busy_o;
    logic [10:0] evt_data_o;
    logic [10:0] q[$];
    int n_cmp = 0, n_bad = 0, wr_cnt = 0;
    int ups[7] = '{528, 560, 624, 752, 880, 1008, 1023};

    tbs_adc_ctrl dut (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .enable_i(enable_i),
        .comp_upper_i(comp_upper_i), .comp_lower_i(comp_lower_i), .delta_i(delta_i),
        .adaptive_i(adaptive_i), .dac_upper_o(dac_upper_o), .dac_lower_o(dac_lower_o),
        .dac_wr_o(dac_wr_o), .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i),
        .evt_data_o(evt_data_o), .fifo_ovf_o(fifo_ovf_o), .sat_hi_o(sat_hi_o),
        .sat_lo_o(sat_lo_o), .busy_o(busy_o)
    );

    always #5 clock_i = ~clock_i;

    always @(negedge clock_i) begin
        #1;
        if (dac_wr_o) wr_cnt++;
        if (evt_valid_o && evt_ready_i) q.push_back(evt_data_o);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        enable_i = 1'b0; comp_upper_i = 1'b0; comp_lower_i = 1'b0;
        adaptive_i = 1'b0; evt_ready_i = 1'b0; delta_i = 6'd16;
        repeat (2) @(negedge clock_i);
        reset_n_i = 1'b1;
        q.delete();
        wr_cnt = 0;
    endtask

    task automatic wait_q(input int n, input string tag);
        int k = 0;
        while (q.size() < n && k < 400) begin
            @(negedge clock_i);
            k++;
        end
        check(tag, 32'(q.size() >= n), 32'd1);
    endtask

    task automatic wait_wr(input int n, input string tag);
        int k = 0;
        while (wr_cnt < n && k < 400) begin
            @(negedge clock_i);
            k++;
        end
        check(tag, 32'(wr_cnt >= n), 32'd1);
    endtask

    initial begin
        #3;
        do_reset();
        check("rst_busy", busy_o, 0);
        check("rst_valid", evt_valid_o, 0);
        check("rst_data", evt_data_o, 0);
        check("rst_upper", dac_upper_o, 512);
        check("rst_lower", dac_lower_o, 512);
        check("rst_wr", dac_wr_o, 0);
        check("rst_flags", {fifo_ovf_o, sat_hi_o, sat_lo_o}, 0);

        enable_i = 1'b1;
        repeat (20) @(negedge clock_i);
        check("first_wr_cnt", wr_cnt, 1);
        check("first_upper", dac_upper_o, 528);
        check("first_lower", dac_lower_o, 496);
        check("first_busy", busy_o, 1);
        check("first_no_evt", q.size(), 0);

        do_reset();
        adaptive_i = 1'b1; evt_ready_i = 1'b1; comp_upper_i = 1'b1; enable_i = 1'b1;
        wait_q(7, "adapt_wait");
        for (int i = 0; i < 7; i++)
            if (i < q.size()) check($sformatf("adapt_evt%0d", i), q[i], 32'h400 + 32'(ups[i]));
        check("adapt_sat_hi", sat_hi_o, 1);
        check("adapt_sat_lo", sat_lo_o, 0);

        do_reset();
        delta_i = 6'd63; comp_lower_i = 1'b1; evt_ready_i = 1'b1; enable_i = 1'b1;
        wait_q(8, "down_wait8");
        if (q.size() >= 8) check("down_evt8", q[7], 8);
        delta_i = 6'd16;
        wait_q(9, "down_wait9");
        if (q.size() >= 9) check("down_evt_zero", q[8], 0);
        check("down_sat_lo", sat_lo_o, 1);
        repeat (3) @(negedge clock_i);
        check("down_lower", dac_lower_o, 0);
        check("down_upper", dac_upper_o, 16);

        do_reset();
        comp_upper_i = 1'b1; enable_i = 1'b1;
        wait_wr(11, "ovf_wait");
        comp_upper_i = 1'b0;
        repeat (8) @(negedge clock_i);
        check("ovf_flag", fifo_ovf_o, 1);
        check("ovf_valid", evt_valid_o, 1);
        check("ovf_head", evt_data_o, 32'h400 + 528);
        check("ovf_upper", dac_upper_o, 688);
        enable_i = 1'b0; evt_ready_i = 1'b1;
        @(negedge clock_i);
        check("ovf_cleared", fifo_ovf_o, 0);
        check("ovf_idle", busy_o, 0);
        repeat (12) @(negedge clock_i);
        check("ovf_count", q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < q.size()) check($sformatf("ovf_evt%0d", i), q[i], 32'h400 + 32'(528 + 16 * i));
        check("ovf_drained", evt_valid_o, 0);
        check("ovf_hold_upper", dac_upper_o, 688);
        check("ovf_hold_lower", dac_lower_o, 656);

        do_reset();
        comp_upper_i = 1'b1; comp_lower_i = 1'b1; evt_ready_i = 1'b1; enable_i = 1'b1;
        repeat (8) @(negedge clock_i);
        wr_cnt = 0;
        repeat (20) @(negedge clock_i);
        check("both_no_wr", wr_cnt, 0);
        check("both_no_evt", q.size(), 0);
        check("both_busy", busy_o, 1);

        do_reset();
        comp_upper_i = 1'b1; enable_i = 1'b1;
        wait_wr(4, "midrst_wait");
        check("midrst_pre_valid", evt_valid_o, 1);
        check("midrst_pre_busy", busy_o, 1);
        reset_n_i = 1'b0;
        #1;
        check("midrst_valid", evt_valid_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_data", evt_data_o, 0);
        check("midrst_upper", dac_upper_o, 512);
        repeat (2) @(negedge clock_i);
        reset_n_i = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
